// File: rtl/fp_mult_arb.sv
// fp_mult_arb: round-robin arbiter sharing one single-precision multiplier between two requesters
module fp_mult #(parameter string ROUND = "away_zero") (
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] z,
  output logic [7:0]  status
);
  localparam logic rn_even = ROUND == "even";
  localparam logic rn_zero = ROUND == "zero";
  localparam logic rn_up   = ROUND == "up";
  localparam logic rn_down = ROUND == "down";
  logic sign, a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, nan, inf, zero, norm;
  logic g, st, inc, ovf, unf, ovf_inf;
  logic [47:0] p;
  logic [22:0] mant;
  logic [23:0] mr;
  logic signed [9:0] e;
  // Subnormal operands read as zero; results below the normal range flush to signed zero.
  always_comb begin
    sign = a[31] ^ b[31];
    a_zero = a[30:23] == 8'd0;
    b_zero = b[30:23] == 8'd0;
    a_inf = &a[30:23] & ~|a[22:0];
    b_inf = &b[30:23] & ~|b[22:0];
    a_nan = &a[30:23] & |a[22:0];
    b_nan = &b[30:23] & |b[22:0];
    nan = a_nan | b_nan | (a_inf & b_zero) | (a_zero & b_inf);
    inf = ~nan & (a_inf | b_inf);
    zero = ~nan & ~inf & (a_zero | b_zero);
    norm = ~nan & ~inf & ~zero;
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    mant = p[47] ? p[46:24] : p[45:23];
    g = p[47] ? p[23] : p[22];
    st = p[47] ? |p[22:0] : |p[21:0];
    inc = rn_even ? g & (st | mant[0]) : rn_zero ? 1'b0 : rn_up ? ~sign & (g | st) :
          rn_down ? sign & (g | st) : g;
    mr = {1'b0, mant} + {23'd0, inc};
    e = 10'(a[30:23]) + 10'(b[30:23]) - 10'd127 + 10'(p[47]) + 10'(mr[23]);
    ovf = e > 10'sd254;
    unf = e < 10'sd1;
    ovf_inf = ~rn_zero & ~(rn_up & sign) & ~(rn_down & ~sign);
    z = nan ? 32'h7FC00000 : inf ? {sign, 8'hFF, 23'd0} : (zero | unf) ? {sign, 31'd0} :
        ovf ? (ovf_inf ? {sign, 8'hFF, 23'd0} : {sign, 8'hFE, 23'h7FFFFF}) : {sign, e[7:0], mr[22:0]};
    status = {2'b00, norm & (g | st | unf | ovf), norm & ovf, norm & unf, nan,
              inf | (norm & ovf & ovf_inf), zero | (norm & unf)};
  end
endmodule

module fp_mult_arb #(parameter string ROUND = "away_zero") (
  input  logic        clk,
  input  logic        rst,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  output logic        res_valid,
  input  logic        res_ready,
  output logic [31:0] res_z,
  output logic [7:0]  res_status,
  output logic        res_id,
  output logic        busy,
  output logic [15:0] op_count
);
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic last_id_q, last_id_d, op_id_q, op_id_d, res_id_q, res_id_d;
  logic [31:0] op_a_q, op_a_d, op_b_q, op_b_d, res_z_q, res_z_d, mul_z;
  logic [7:0] res_status_q, res_status_d, mul_status;
  logic [15:0] op_count_q, op_count_d;
  logic idle, grant0, grant1, hs0, hs1;

  fp_mult #(.ROUND(ROUND)) u_mult (.a(op_a_q), .b(op_b_q), .z(mul_z), .status(mul_status));

  // On a tie the requester not served last wins; grant1 excludes grant0 by construction.
  always_comb begin
    idle = state_q == IDLE;
    grant0 = req0_valid & (~req1_valid | last_id_q);
    grant1 = req1_valid & ~grant0;
    req0_ready = ~rst & idle & grant0;
    req1_ready = ~rst & idle & grant1;
    hs0 = req0_valid & req0_ready;
    hs1 = req1_valid & req1_ready;
    state_d = idle ? ((hs0 | hs1) ? CALC : IDLE) : state_q == CALC ? DONE : (res_ready ? IDLE : DONE);
    last_id_d = (hs0 | hs1) ? hs1 : last_id_q;
    op_id_d = (hs0 | hs1) ? hs1 : op_id_q;
    op_a_d = hs0 ? req0_a : hs1 ? req1_a : op_a_q;
    op_b_d = hs0 ? req0_b : hs1 ? req1_b : op_b_q;
    res_z_d = state_q == CALC ? mul_z : res_z_q;
    res_status_d = state_q == CALC ? mul_status : res_status_q;
    res_id_d = state_q == CALC ? op_id_q : res_id_q;
    op_count_d = op_count_q + {15'd0, state_q == DONE & res_ready};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      last_id_q <= 1'b1;
      op_id_q <= 1'b0;
      op_a_q <= '0;
      op_b_q <= '0;
      res_z_q <= '0;
      res_status_q <= '0;
      res_id_q <= 1'b0;
      op_count_q <= '0;
    end else begin
      state_q <= state_d;
      last_id_q <= last_id_d;
      op_id_q <= op_id_d;
      op_a_q <= op_a_d;
      op_b_q <= op_b_d;
      res_z_q <= res_z_d;
      res_status_q <= res_status_d;
      res_id_q <= res_id_d;
      op_count_q <= op_count_d;
    end
  end

  assign res_valid = state_q == DONE;
  assign busy = ~rst & ~idle;
  assign res_z = res_z_q;
  assign res_status = res_status_q;
  assign res_id = res_id_q;
  assign op_count = op_count_q;
endmodule

// File: tb/tb_fp_mult_arb.sv
// tb_fp_mult_arb: scoreboard bench for the two-requester multiplier arbiter
module tb_fp_mult_arb;
  logic clk = 1'b0, rst = 1'b1;
  logic req0_valid = 1'b0, req1_valid = 1'b0, res_ready = 1'b0;
  logic [31:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
  logic req0_ready, req1_ready, res_valid, res_id, busy;
  logic [31:0] res_z;
  logic [7:0] res_status;
  logic [15:0] op_count;

  typedef struct packed {logic [31:0] z; logic [7:0] st; logic id;} exp_t;
  exp_t sb[$];
  exp_t mon_e;
  int n_tests = 0, n_fail = 0;
  logic [15:0] exp_count = '0;
  logic exp_last = 1'b1, exp_id;
  logic [1:0] rdy;
  int cyc;
  bit ok;

  fp_mult_arb dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_z(res_z), .res_status(res_status),
    .res_id(res_id), .busy(busy), .op_count(op_count)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Every consumed result is checked against the oldest expectation.
  always @(negedge clk) begin
    if (res_valid && res_ready) begin
      n_tests++;
      if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL result_unexpected: got z=%h st=%h id=%0d, expected no result", res_z, res_status, res_id);
      end else begin
        mon_e = sb.pop_front();
        if ({res_z, res_status, res_id} !== mon_e) begin
          n_fail++;
          $display("FAIL result: got z=%h st=%h id=%0d, expected z=%h st=%h id=%0d",
                   res_z, res_status, res_id, mon_e.z, mon_e.st, mon_e.id);
        end
        exp_count++;
      end
    end
  end

  task automatic wait_grant(output logic [1:0] r, output int n);
    r = 2'b00;
    n = 0;
    while (n < 10 && r == 2'b00) begin
      @(negedge clk);
      n++;
      r = {req1_ready, req0_ready};
    end
  endtask

  task automatic issue(input logic id, input logic [31:0] a, input logic [31:0] b, output logic [1:0] r);
    int n;
    if (id) begin req1_a = a; req1_b = b; req1_valid = 1'b1; end
    else begin req0_a = a; req0_b = b; req0_valid = 1'b1; end
    wait_grant(r, n);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic drain(output bit d);
    d = 1'b0;
    for (int i = 0; i < 20 && !d; i++) begin
      @(posedge clk); #1;
      d = sb.size() == 0 && !busy;
    end
  endtask

  task automatic do_reset;
    rst = 1'b1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    exp_count = '0;
    exp_last = 1'b1;
  endtask

  task automatic test_reset;
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; res_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++;
    if ({req0_ready, req1_ready, busy} !== 3'b000) begin
      n_fail++; $display("FAIL reset_ready: got r0=%b r1=%b busy=%b, expected 0 0 0", req0_ready, req1_ready, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
    n_tests++;
    if ({res_valid, res_z, res_status, res_id, op_count} !== '0) begin
      n_fail++; $display("FAIL reset_state: got v=%b z=%h st=%h id=%b cnt=%h, expected all zero",
                         res_valid, res_z, res_status, res_id, op_count);
    end
  endtask

  task automatic test_single;
    res_ready = 1'b1;
    req0_a = 32'h40000000; req0_b = 32'h40400000; req0_valid = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({req1_ready, req0_ready} !== 2'b01) begin
      n_fail++; $display("FAIL single_grant: got ready=%b, expected 01", {req1_ready, req0_ready});
    end
    sb.push_back({32'h40C00000, 8'h00, 1'b0});
    exp_last = 1'b0;
    @(posedge clk); #1 req0_valid = 1'b0;
    @(negedge clk);
    n_tests++;
    if ({res_valid, busy, req0_ready} !== 3'b010) begin
      n_fail++; $display("FAIL single_t1: got valid=%b busy=%b ready=%b, expected 0 1 0", res_valid, busy, req0_ready);
    end
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b1) begin
      n_fail++; $display("FAIL single_t2: got res_valid=%b, expected 1", res_valid);
    end
    @(posedge clk); #1;
    n_tests++;
    if ({busy, op_count} !== {1'b0, 16'd1}) begin
      n_fail++; $display("FAIL single_count: got busy=%b cnt=%0d, expected 0 1", busy, op_count);
    end
  endtask

  task automatic test_round_robin;
    do_reset();
    res_ready = 1'b1;
    req0_a = 32'h3FC00000; req0_b = 32'h3FC00000;
    req1_a = 32'h3F800000; req1_b = 32'h40000000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      wait_grant(rdy, cyc);
      exp_id = ~exp_last;
      n_tests++;
      if (rdy !== (exp_id ? 2'b10 : 2'b01) || (i > 0 && cyc != 3)) begin
        n_fail++; $display("FAIL rr_grant %0d: got ready=%b after %0d cycles, expected %b after 3",
                           i, rdy, cyc, exp_id ? 2'b10 : 2'b01);
      end
      sb.push_back(exp_id ? {32'h40000000, 8'h00, 1'b1} : {32'h40100000, 8'h00, 1'b0});
      exp_last = exp_id;
      @(posedge clk); #1;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(ok);
    n_tests++;
    if (!ok || op_count !== exp_count) begin
      n_fail++; $display("FAIL rr_drain: got drained=%b cnt=%0d, expected 1 %0d", ok, op_count, exp_count);
    end
  endtask

  task automatic test_backpressure;
    res_ready = 1'b0;
    req0_a = 32'h40000000; req0_b = 32'h40400000; req0_valid = 1'b1;
    wait_grant(rdy, cyc);
    n_tests++;
    if (rdy !== 2'b01) begin
      n_fail++; $display("FAIL bp_grant: got ready=%b, expected 01", rdy);
    end
    sb.push_back({32'h40C00000, 8'h00, 1'b0});
    exp_last = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b1; req1_a = 32'h3F800000; req1_b = 32'h3F800000;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_tests++;
      if ({res_valid, busy, req0_ready, req1_ready, res_z, res_id} !== {4'b1100, 32'h40C00000, 1'b0}) begin
        n_fail++; $display("FAIL bp_hold %0d: got v=%b busy=%b r=%b%b z=%h id=%b, expected 1 1 00 40c00000 0",
                           i, res_valid, busy, req0_ready, req1_ready, res_z, res_id);
      end
    end
    @(posedge clk); #1 res_ready = 1'b1;
    @(negedge clk);
    n_tests++;
    if (res_valid !== 1'b1) begin
      n_fail++; $display("FAIL bp_accept: got res_valid=%b, expected 1", res_valid);
    end
    @(negedge clk);
    n_tests++;
    if ({busy, req1_ready} !== 2'b01) begin
      n_fail++; $display("FAIL bp_idle: got busy=%b r1=%b, expected 0 1", busy, req1_ready);
    end
    req1_valid = 1'b0;
    @(posedge clk); #1;
    n_tests++;
    if ({busy, op_count} !== {1'b0, exp_count}) begin
      n_fail++; $display("FAIL bp_withdraw: got busy=%b cnt=%0d, expected 0 %0d", busy, op_count, exp_count);
    end
  endtask

  task automatic test_special;
    res_ready = 1'b1;
    sb.push_back({32'h00000000, 8'h01, 1'b1});
    issue(1'b1, 32'h00000000, 32'h41200000, rdy);
    drain(ok);
    sb.push_back({32'h7FC00000, 8'h04, 1'b1});
    issue(1'b1, 32'h7FC00000, 32'h41200000, rdy);
    drain(ok);
    sb.push_back({32'h7F800000, 8'h32, 1'b0});
    issue(1'b0, 32'h7F000000, 32'h7F000000, rdy);
    drain(ok);
    sb.push_back({32'h3F800002, 8'h20, 1'b0});
    issue(1'b0, 32'h3F800001, 32'h3F800001, rdy);
    drain(ok);
    n_tests++;
    if (!ok || op_count !== exp_count) begin
      n_fail++; $display("FAIL special_drain: got drained=%b cnt=%0d, expected 1 %0d", ok, op_count, exp_count);
    end
  endtask

  task automatic test_reset_calc;
    res_ready = 1'b1;
    req0_a = 32'h3FC00000; req0_b = 32'h3FC00000; req0_valid = 1'b1;
    wait_grant(rdy, cyc);
    @(posedge clk); #1;
    req0_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_tests++;
    if ({req0_ready, req1_ready, busy} !== 3'b000) begin
      n_fail++; $display("FAIL rstcalc_inrst: got r0=%b r1=%b busy=%b, expected 0 0 0", req0_ready, req1_ready, busy);
    end
    @(posedge clk); #1;
    rst = 1'b0; sb.delete(); exp_count = '0; exp_last = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_tests++;
      if ({res_valid, busy, op_count} !== 18'd0) begin
        n_fail++; $display("FAIL rstcalc_quiet %0d: got v=%b busy=%b cnt=%0d, expected 0 0 0", i, res_valid, busy, op_count);
      end
    end
    @(posedge clk); #1;
    req1_a = 32'h3F800000; req1_b = 32'h40000000;
    req0_valid = 1'b1; req1_valid = 1'b1;
    wait_grant(rdy, cyc);
    n_tests++;
    if (rdy !== 2'b01) begin
      n_fail++; $display("FAIL rstcalc_tie: got ready=%b, expected 01", rdy);
    end
    sb.push_back({32'h40100000, 8'h00, 1'b0});
    exp_last = 1'b0;
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0;
    drain(ok);
    n_tests++;
    if (!ok || op_count !== 16'd1) begin
      n_fail++; $display("FAIL rstcalc_count: got drained=%b cnt=%0d, expected 1 1", ok, op_count);
    end
  endtask

  // Preloads the counter near its limit instead of spending 65536 transactions.
  task automatic test_wrap;
    res_ready = 1'b1;
    force dut.op_count_q = 16'hFFFE;
    @(posedge clk); #1;
    release dut.op_count_q;
    exp_count = 16'hFFFE;
    for (int i = 0; i < 2; i++) begin
      sb.push_back({32'h40C00000, 8'h00, 1'b0});
      issue(1'b0, 32'h40000000, 32'h40400000, rdy);
      drain(ok);
      n_tests++;
      if (op_count !== exp_count) begin
        n_fail++; $display("FAIL wrap_step %0d: got cnt=%h, expected %h", i, op_count, exp_count);
      end
    end
    n_tests++;
    if (op_count !== 16'h0000) begin
      n_fail++; $display("FAIL wrap_zero: got cnt=%h, expected 0000", op_count);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure();
    test_special();
    test_reset_calc();
    test_wrap();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_left: got %0d pending, expected 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
